memory_access_unit: RTL

Pipeline stage directly downstream of the execute stage. Registers the execute results, performs data-memory loads/stores over a req/ack bus, aligns store data and byte enables, and extracts and extends load data. Stalls the upstream pipeline while an access is outstanding. Produces the write-back bundle and the memory-stage forwarding value.

---
 rtl/multicore_pkg.sv | 60 ++++++
 rtl/mem_align.sv | 50 +++++
 rtl/memory_access_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/multicore_pkg.sv
// Shared types for the multicore pipeline.
// Memory-stage opcodes, stage bundle and FSM state.
package multicore_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      LD_LB,
      LD_LH,
      LD_LW,
      LD_LBU,
      LD_LHU
   } t_ldop;

   typedef enum logic [1:0] {
      ST_SB,
      ST_SH,
      ST_SW
   } t_sop;

   typedef enum logic [1:0] {
      MTR_ALU = 2'b00,
      MTR_MEM = 2'b01,
      MTR_PC  = 2'b10
   } t_memtoreg;

   typedef enum logic {
      MA_IDLE,
      MA_ACCESS
   } t_ma_state;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] calc;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] pc4;
      logic              regwrite;
      logic [1:0]        memtoreg;
      logic              memwrite;
      t_ldop             ldop;
      t_sop              sop;
   } ma_stage_t;

   function automatic logic misaligned(
      input logic [1:0] off,
      input logic       st,
      input t_ldop      ld,
      input t_sop       so
   );
      logic half;
      logic word;
      half = st ? (so == ST_SH)
                : (ld == LD_LH || ld == LD_LHU);
      word = st ? (so == ST_SW)
                : (ld == LD_LW);
      return (half & off[0])
           | (word & (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane/byte-enable generation and
// load extract/extend; purely combinational.
module mem_align
   import multicore_pkg::*;
(
   input  logic [1:0]        off,
   input  logic              is_store,
   input  t_sop              sop,
   input  t_ldop             ldop,
   input  logic [DATA_W-1:0] st_data,
   input  logic [DATA_W-1:0] ld_word,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] st_lane,
   output logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0] sh;

   // store lanes: replicate so any lane carries the data
   always_comb begin
      be      = 4'hF;
      st_lane = st_data;
      if (is_store) begin
         unique case (sop)
            ST_SB: begin
               be      = 4'b0001 << off;
               st_lane = {4{st_data[7:0]}};
            end
            ST_SH: begin
               be      = off[1] ? 4'b1100 : 4'b0011;
               st_lane = {2{st_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // load: move addressed byte/half to bit 0, then extend
   always_comb begin
      sh = ld_word >> {off, 3'b000};
      unique case (ldop)
         LD_LB:   ld_data = {{24{sh[7]}}, sh[7:0]};
         LD_LH:   ld_data = {{16{sh[15]}}, sh[15:0]};
         LD_LBU:  ld_data = {24'h0, sh[7:0]};
         LD_LHU:  ld_data = {16'h0, sh[15:0]};
         default: ld_data = sh;
      endcase
   end

endmodule

// File: rtl/memory_access_unit.sv
// Memory pipeline stage: registers execute results,
// runs req/ack data-memory accesses, builds write-back.
module memory_access_unit
   import multicore_pkg::*;
#(
   parameter int DATA_SIZE = DATA_W,
   parameter int NUM_REGS  = 32,
   localparam int RW       = $clog2(NUM_REGS)
) (
   input  logic                 i_aclk,
   input  logic                 i_areset_n,
   input  logic                 i_en,
   input  logic [DATA_SIZE-1:0] i_exe_calc,
   input  logic [DATA_SIZE-1:0] i_exe_wdata,
   input  logic [DATA_SIZE-1:0] i_pcplus4,
   input  logic [RW-1:0]        i_rdest,
   input  logic                 i_cu_regwrite,
   input  logic [1:0]           i_cu_memtoreg,
   input  logic                 i_cu_memwrite,
   input  t_ldop                i_ldop,
   input  t_sop                 i_sop,
   output logic                 o_stall,
   output logic [DATA_SIZE-1:0] o_forward_data,
   output logic                 o_dmem_req,
   output logic                 o_dmem_we,
   output logic [DATA_SIZE-1:0] o_dmem_addr,
   output logic [3:0]           o_dmem_be,
   output logic [DATA_SIZE-1:0] o_dmem_wdata,
   input  logic                 i_dmem_ack,
   input  logic [DATA_SIZE-1:0] i_dmem_rdata,
   output logic [DATA_SIZE-1:0] o_wb_data,
   output logic [RW-1:0]        o_wb_rdest,
   output logic                 o_wb_regwrite,
   output logic                 o_wb_misaligned
);

   ma_stage_t      s;
   logic [RW-1:0]  s_rdest;
   t_ma_state      state;

   logic           s_load;
   logic           s_store;
   logic           s_mis;
   logic           in_go;
   logic [DATA_SIZE-1:0] ld_data;
   logic [DATA_SIZE-1:0] result;

   assign s_load  = s.valid & (s.memtoreg == MTR_MEM);
   assign s_store = s.valid & s.memwrite;
   assign s_mis   = (s_load | s_store)
                  & misaligned(s.calc[1:0], s.memwrite,
                               s.ldop, s.sop);

   assign in_go = i_en
                & ((i_cu_memtoreg == MTR_MEM) | i_cu_memwrite)
                & ~misaligned(i_exe_calc[1:0], i_cu_memwrite,
                              i_ldop, i_sop);

   assign o_dmem_req  = (state == MA_ACCESS);
   assign o_stall     = o_dmem_req & ~i_dmem_ack;
   assign o_dmem_we   = s.memwrite;
   assign o_dmem_addr = {s.calc[DATA_SIZE-1:2], 2'b00};

   assign o_forward_data = (s.memtoreg == MTR_PC) ? s.pc4
                                                  : s.calc;

   mem_align u_align (
      .off      (s.calc[1:0]),
      .is_store (s.memwrite),
      .sop      (s.sop),
      .ldop     (s.ldop),
      .st_data  (s.wdata),
      .ld_word  (i_dmem_rdata),
      .be       (o_dmem_be),
      .st_lane  (o_dmem_wdata),
      .ld_data  (ld_data)
   );

   // write-back value select; reserved code falls to ALU
   always_comb begin
      unique case (1'b1)
         (s.memtoreg == MTR_MEM): result = ld_data;
         (s.memtoreg == MTR_PC):  result = s.pc4;
         default:                 result = s.calc;
      endcase
   end

   // access FSM: advances only on edges where the stage moves
   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n)
         state <= MA_IDLE;
      else if (!o_stall)
         state <= in_go ? MA_ACCESS : MA_IDLE;
   end

   // stage register: capture or bubble unless stalled
   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         s       <= '0;
         s_rdest <= '0;
      end else if (!o_stall) begin
         s.valid    <= i_en;
         s.calc     <= i_exe_calc;
         s.wdata    <= i_exe_wdata;
         s.pc4      <= i_pcplus4;
         s.ldop     <= i_ldop;
         s.sop      <= i_sop;
         s_rdest    <= i_rdest;
         s.regwrite <= i_en & i_cu_regwrite;
         s.memwrite <= i_en & i_cu_memwrite;
         s.memtoreg <= i_en ? i_cu_memtoreg : 2'b00;
      end
   end

   // write-back register: loads on completion, else pulses clear
   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         o_wb_data       <= '0;
         o_wb_rdest      <= '0;
         o_wb_regwrite   <= 1'b0;
         o_wb_misaligned <= 1'b0;
      end else if (!o_stall) begin
         o_wb_data       <= result;
         o_wb_rdest      <= s_rdest;
         o_wb_regwrite   <= s.regwrite & s.valid
                          & ~s.memwrite & ~s_mis;
         o_wb_misaligned <= s_mis;
      end else begin
         o_wb_regwrite   <= 1'b0;
         o_wb_misaligned <= 1'b0;
      end
   end

endmodule
